// File: rtl/shiftreg_seq.sv
// Parametrised shift register with single-step and counted multi-step shifts.
// Four modes: logical/arithmetic right, left, rotate right; shift_out taps the lost bit.
module shiftreg_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] data_in,
   input  logic             shift,
   input  logic             start,
   input  logic [CNT_W-1:0] shamt,
   input  logic [1:0]       mode,
   input  logic             s_in,
   output logic [WIDTH-1:0] data_out,
   output logic             shift_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             sout_q, sout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [1:0]       step_mode;
   logic [WIDTH-1:0] step_data;
   logic             step_out;

   // A running sequence uses the mode latched at start, not the live input
   assign step_mode = (state_q == RUN) ? mode_q : mode;

   always_comb begin
      step_data = data_q;
      step_out  = data_q[0];
      case (step_mode)
         2'b00: step_data = {s_in, data_q[WIDTH-1:1]};
         2'b01: step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
         2'b10: begin
            step_data = {data_q[WIDTH-2:0], s_in};
            step_out  = data_q[WIDTH-1];
         end
         default: step_data = {data_q[0], data_q[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sout_d  = sout_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ld) begin
               data_d = data_in;
            end else if (start) begin
               if (shamt != '0) begin
                  mode_d  = mode;
                  cnt_d   = shamt;
                  state_d = RUN;
                  busy_d  = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end else if (shift) begin
               data_d = step_data;
               sout_d = step_out;
            end
         end
         RUN: begin
            data_d = step_data;
            sout_d = step_out;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         data_q  <= '0;
         sout_q  <= 1'b0;
         cnt_q   <= '0;
         mode_q  <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sout_q  <= sout_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign data_out  = data_q;
   assign shift_out = sout_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_shiftreg_seq.sv
// Directed bench for shiftreg_seq at WIDTH=8, CNT_W=4.
// Expected values are hand-computed constants.
module tb_shiftreg_seq;

   logic       clk;
   logic       clr;
   logic       ld;
   logic [7:0] data_in;
   logic       shift;
   logic       start;
   logic [3:0] shamt;
   logic [1:0] mode;
   logic       s_in;
   logic [7:0] data_out;
   logic       shift_out;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;
   int bc;

   shiftreg_seq #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk),
      .clr(clr),
      .ld(ld),
      .data_in(data_in),
      .shift(shift),
      .start(start),
      .shamt(shamt),
      .mode(mode),
      .s_in(s_in),
      .data_out(data_out),
      .shift_out(shift_out),
      .busy(busy),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] d, input logic so,
                          input logic b, input logic dn);
      chk({tag, ".data"}, 32'(data_out), 32'(d));
      chk({tag, ".sout"}, 32'(shift_out), 32'(so));
      chk({tag, ".busy"}, 32'(busy), 32'(b));
      chk({tag, ".done"}, 32'(done), 32'(dn));
   endtask

   initial begin
      clr = 1'b1; ld = 1'b0; data_in = 8'h00; shift = 1'b0;
      start = 1'b0; shamt = 4'd0; mode = 2'b00; s_in = 1'b0;
      tick();
      chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      clr = 1'b0;

      // single-step compatibility
      ld = 1'b1; data_in = 8'hA5;
      tick();
      chk("ld_a5", 32'(data_out), 32'h A5);
      ld = 1'b0; shift = 1'b1; mode = 2'b00; s_in = 1'b1;
      tick();
      shift = 1'b0;
      chk_all("step00", 8'hD2, 1'b1, 1'b0, 1'b0);

      // arithmetic sequence, live mode change must be ignored
      ld = 1'b1; data_in = 8'h96;
      tick();
      ld = 1'b0; start = 1'b1; mode = 2'b01; shamt = 4'd3;
      tick();
      start = 1'b0; mode = 2'b00; shamt = 4'd9;
      chk_all("ar_start", 8'h96, 1'b1, 1'b1, 1'b0);
      tick();
      chk_all("ar_s1", 8'hCB, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("ar_s2", 8'hE5, 1'b1, 1'b1, 1'b0);
      tick();
      chk_all("ar_s3", 8'hF2, 1'b1, 1'b0, 1'b1);
      tick();
      chk_all("ar_post", 8'hF2, 1'b1, 1'b0, 1'b0);

      // left with fill, ld while busy ignored
      ld = 1'b1; data_in = 8'h81;
      tick();
      ld = 1'b0; start = 1'b1; mode = 2'b10; shamt = 4'd2; s_in = 1'b0;
      tick();
      start = 1'b0; ld = 1'b1; data_in = 8'hFF;
      tick();
      chk_all("lf_s1", 8'h02, 1'b1, 1'b1, 1'b0);
      tick();
      ld = 1'b0;
      chk_all("lf_s2", 8'h04, 1'b0, 1'b0, 1'b1);

      // rotate full width
      ld = 1'b1; data_in = 8'h3C;
      tick();
      ld = 1'b0; start = 1'b1; mode = 2'b11; shamt = 4'd8;
      tick();
      start = 1'b0;
      bc = 0;
      for (int i = 0; i < 8; i++) begin
         if (busy) bc++;
         tick();
      end
      chk("rot_busy_cycles", 32'(bc), 32'd8);
      chk_all("rot_end", 8'h3C, 1'b0, 1'b0, 1'b1);
      tick();
      chk("rot_done_once", 32'(done), 32'd0);

      // abort by clr on the second RUN cycle
      ld = 1'b1; data_in = 8'h96;
      tick();
      ld = 1'b0; start = 1'b1; mode = 2'b01; shamt = 4'd5;
      tick();
      start = 1'b0;
      tick();
      chk("ab_s1", 32'(data_out), 32'hCB);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk_all("ab_clr", 8'h00, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("ab_nodone%0d", i), 32'(done), 32'd0);
      end

      // zero count, then back-to-back start in the done cycle
      ld = 1'b1; data_in = 8'h5A;
      tick();
      ld = 1'b0; start = 1'b1; shamt = 4'd0; mode = 2'b00;
      tick();
      chk_all("z_done", 8'h5A, 1'b0, 1'b0, 1'b1);
      shamt = 4'd1; s_in = 1'b0;
      tick();
      start = 1'b0;
      chk_all("bb_start", 8'h5A, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("bb_s1", 8'h2D, 1'b0, 1'b0, 1'b1);
      tick();
      chk("bb_post", 32'(done), 32'd0);

      // long count beyond width fills with s_in
      start = 1'b1; mode = 2'b00; shamt = 4'd10; s_in = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk_all("fill", 8'hFF, 1'b1, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shiftreg_seq.md
Name: shiftreg_seq

Overview:
Parametrised successor to the team's 8-bit right shift register, used for datapath operand registers in the Booth multiplier and related sequential arithmetic units.
- Keeps the single-step load/shift behaviour.
- Adds four shift modes and a sequenced multi-step shift: a start/busy/done handshake runs a counted number of shifts autonomously, one per clock.
- Adds a shift-out bit for carry/Booth-bit extraction.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of the shift-amount input; max sequenced shift = 2^CNT_W-1

Ports:
clk  input  1  clock; all state updates on posedge
clr  input  1  synchronous active-high reset/clear
ld  input  1  parallel load of data_in
data_in  input  WIDTH  parallel load value
shift  input  1  single-step shift using live mode/s_in (idle only)
start  input  1  begin sequenced shift of shamt steps (idle only)
shamt  input  CNT_W  number of steps for sequenced shift, sampled at start
mode  input  2  00 logical right, 01 arithmetic right, 10 left, 11 rotate right
s_in  input  1  serial-in bit for modes 00 and 10, sampled live on every step
data_out  output  WIDTH  register contents
shift_out  output  1  bit shifted out on the most recent step
busy  output  1  high while a sequenced shift is in progress
done  output  1  one-cycle pulse when a sequenced shift completes

Behaviour:
- Reset: clr=1 at a posedge sets data_out=0, shift_out=0, busy=0, done=0, FSM=IDLE. clr has top priority in every state and aborts a running sequence; no done pulse follows.
- Step definitions (d = data_out, W = WIDTH):
  - 00: d <= {s_in, d[W-1:1]}, out=d[0]
  - 01: d <= {d[W-1], d[W-1:1]}, out=d[0]
  - 10: d <= {d[W-2:0], s_in}, out=d[W-1]
  - 11: d <= {d[0], d[W-1:1]}, out=d[0]
  - shift_out takes "out" on every step and holds otherwise.
- FSM states: IDLE, RUN.
- IDLE priority: clr > ld > start > shift.
  - ld: data_out <= data_in; shift_out unchanged.
  - start with shamt!=0: latch mode and shamt into internal registers, go to RUN, busy=1 from the next cycle. No shift occurs on the start edge.
  - start with shamt==0: stay in IDLE, no shift, done=1 for the next cycle.
  - shift: one step using live mode.
- RUN: one step per clock using the latched mode and live s_in; remaining-count decrements.
  - On the edge performing the last step: go to IDLE, busy<=0, done<=1 for one cycle.
  - Latency: start at edge k gives steps at edges k+1..k+n (n = latched shamt). busy is high between edges k and k+n. done is high for the cycle after edge k+n.
  - ld, start and shift are ignored while busy. mode and shamt changes during RUN have no effect.
- done is registered, high for exactly one cycle, and low otherwise. Back-to-back operation: a start in the done cycle is accepted, since the FSM is in IDLE.
- shamt may exceed WIDTH; exactly shamt steps are performed with no clamping. For example, mode 00 with shamt>=W fills the register with the successive s_in values.
- The internal counter is CNT_W bits and never wraps, because it counts down from a nonzero value to 0.

Test Plan:
- Single-step compatibility (WIDTH=8): clr, then ld 0xA5, then one shift with mode=00, s_in=1 -> data_out=0xD2, shift_out=1, busy=0, done=0.
- Arithmetic sequence: ld 0x96, start mode=01 shamt=3 -> data_out goes 0xCB, 0xE5, 0xF2 on successive edges; busy high for 3 cycles; done pulses one cycle after the 3rd step; shift_out=1.
- Left with fill: ld 0x81, start mode=10 shamt=2, s_in=0 -> data_out=0x04, shift_out=0. Assert ld 0xFF while busy -> ignored, result still 0x04.
- Rotate full width: ld 0x3C, start mode=11 shamt=8 -> data_out=0x3C after 8 steps, busy exactly 8 cycles, done exactly 1 cycle.
- Abort: ld 0x96, start mode=01 shamt=5, clr asserted on the 2nd RUN cycle -> data_out=0, busy=0, shift_out=0; done stays 0 for the following 6 cycles.
- Zero count and back-to-back: start shamt=0 on 0x5A -> data unchanged, done pulses next cycle, busy never high. start mode=00 shamt=1 s_in=0 in that done cycle -> data_out=0x2D and a second done pulse.
